// File: rtl/decoder_blk2raster_if.sv
// Stream bundle between the block-to-raster buffer and its neighbours:
// 2x8 pixel blocks in from colour conversion, 8-pixel row segments out.
interface decoder_blk2raster_if;
    logic         in_valid;
    logic [671:0] in_p;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [335:0] out_p;
    logic [3:0]   out_npx;
    logic         out_sol;
    logic         out_eol;

    modport slave (
        input  in_valid, in_p, out_ready,
        output in_ready, out_valid, out_p, out_npx, out_sol, out_eol
    );

    modport master (
        output in_valid, in_p, out_ready,
        input  in_ready, out_valid, out_p, out_npx, out_sol, out_eol
    );
endinterface

// File: rtl/decoder_blk2raster.sv
// Block-to-raster reorder buffer. Two ping-pong banks each hold one 2-line band
// of 2x8 blocks. Once a bank is full it is read back row 0 then row 1 as 8-pixel
// segments, while the other bank fills.
module decoder_blk2raster #(
    parameter int MAX_SLICE_WIDTH = 2560
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush,
    input  logic [$clog2(MAX_SLICE_WIDTH)-1:0] slice_width,
    decoder_blk2raster_if.slave                io,
    output logic                               overflow_err
);
    localparam int DEPTH = MAX_SLICE_WIDTH / 8;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SWW   = $clog2(MAX_SLICE_WIDTH);
    localparam int PW    = 14;
    localparam int SEG_W = 24 * PW;

    typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL, BANK_DRAINING} bank_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_ROW0, RD_ROW1} rd_state_t;

    // Storage indexed by {bank, row}, then block column within the band.
    logic [SEG_W-1:0] mem [4][DEPTH];

    bank_state_t      bank_q [2];
    bank_state_t      bank_d [2];
    rd_state_t        rd_q, rd_d;
    logic             wb, wb_d, rb, rb_d;
    logic [AW-1:0]    wcnt, wcnt_d, rcnt, rcnt_d;
    logic             in_ready_d;
    logic             out_last, out_bank;

    logic [SWW:0]     sw_plus7;
    logic [AW-1:0]    nb_m1;
    logic [3:0]       last_npx;
    logic [SEG_W-1:0] wr_row0, wr_row1;
    logic             wr_en, wr_last, rd_last, out_load, out_hs;

    // Band geometry: blocks per band minus one, and pixel count of the final segment.
    always_comb begin
        sw_plus7 = {1'b0, slice_width} + (SWW+1)'(7);
        nb_m1    = AW'(sw_plus7 >> 3) - AW'(1);
        last_npx = (slice_width[2:0] == 3'd0) ? 4'd8 : {1'b0, slice_width[2:0]};
    end

    // Split an incoming block into its two row segments in output pixel layout.
    always_comb begin
        wr_row0 = '0;
        wr_row1 = '0;
        for (int cp = 0; cp < 3; cp++) begin
            for (int c = 0; c < 8; c++) begin
                wr_row0[(cp*8+c)*PW +: PW] = io.in_p[(cp*16+c)*PW +: PW];
                wr_row1[(cp*8+c)*PW +: PW] = io.in_p[(cp*16+8+c)*PW +: PW];
            end
        end
    end

    assign wr_en    = io.in_valid & io.in_ready & ~flush;
    assign wr_last  = (wcnt == nb_m1);
    assign rd_last  = (rcnt == nb_m1);
    assign out_load = (rd_q != RD_IDLE) & (~io.out_valid | io.out_ready);
    assign out_hs   = io.out_valid & io.out_ready;

    // Next bank states, write/read pointers and reader FSM; writer, reader and
    // release always act on banks in different states, so they never collide.
    always_comb begin
        bank_d = bank_q;
        wb_d   = wb;
        wcnt_d = wcnt;
        rd_d   = rd_q;
        rb_d   = rb;
        rcnt_d = rcnt;
        if (wr_en) begin
            if (wr_last) begin
                bank_d[wb] = BANK_FULL;
                wcnt_d     = '0;
                wb_d       = ~wb;
            end else begin
                bank_d[wb] = BANK_FILLING;
                wcnt_d     = wcnt + AW'(1);
            end
        end
        if (out_hs && out_last) begin
            bank_d[out_bank] = BANK_EMPTY;
        end
        case (rd_q)
            RD_IDLE: begin
                if (bank_q[rb] == BANK_FULL) begin
                    rd_d       = RD_ROW0;
                    rcnt_d     = '0;
                    bank_d[rb] = BANK_DRAINING;
                end
            end
            RD_ROW0: begin
                if (out_load) begin
                    if (rd_last) begin
                        rd_d   = RD_ROW1;
                        rcnt_d = '0;
                    end else begin
                        rcnt_d = rcnt + AW'(1);
                    end
                end
            end
            RD_ROW1: begin
                if (out_load) begin
                    if (rd_last) begin
                        rcnt_d = '0;
                        rb_d   = ~rb;
                        if (bank_q[~rb] == BANK_FULL) begin
                            rd_d        = RD_ROW0;
                            bank_d[~rb] = BANK_DRAINING;
                        end else begin
                            rd_d = RD_IDLE;
                        end
                    end else begin
                        rcnt_d = rcnt + AW'(1);
                    end
                end
            end
            default: rd_d = RD_IDLE;
        endcase
        in_ready_d = (bank_d[wb_d] == BANK_EMPTY) || (bank_d[wb_d] == BANK_FILLING);
    end

    // Control state register: bank states, pointers, reader FSM, in_ready and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q[0]    <= BANK_EMPTY;
            bank_q[1]    <= BANK_EMPTY;
            rd_q         <= RD_IDLE;
            wb           <= 1'b0;
            rb           <= 1'b0;
            wcnt         <= '0;
            rcnt         <= '0;
            io.in_ready  <= 1'b1;
            overflow_err <= 1'b0;
        end else if (flush) begin
            bank_q[0]    <= BANK_EMPTY;
            bank_q[1]    <= BANK_EMPTY;
            rd_q         <= RD_IDLE;
            wb           <= 1'b0;
            rb           <= 1'b0;
            wcnt         <= '0;
            rcnt         <= '0;
            io.in_ready  <= 1'b1;
            overflow_err <= 1'b0;
        end else begin
            bank_q       <= bank_d;
            rd_q         <= rd_d;
            wb           <= wb_d;
            rb           <= rb_d;
            wcnt         <= wcnt_d;
            rcnt         <= rcnt_d;
            io.in_ready  <= in_ready_d;
            overflow_err <= overflow_err | (io.in_valid & ~io.in_ready);
        end
    end

    // Band storage: both rows of an accepted block land in the current write bank.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wb, 1'b0}][wcnt] <= wr_row0;
            mem[{wb, 1'b1}][wcnt] <= wr_row1;
        end
    end

    // Output register: loads the segment the reader points at whenever it is free
    // or being consumed, and holds steady while the downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io.out_valid <= 1'b0;
            io.out_p     <= '0;
            io.out_npx   <= '0;
            io.out_sol   <= 1'b0;
            io.out_eol   <= 1'b0;
            out_last     <= 1'b0;
            out_bank     <= 1'b0;
        end else if (flush) begin
            io.out_valid <= 1'b0;
            io.out_p     <= '0;
            io.out_npx   <= '0;
            io.out_sol   <= 1'b0;
            io.out_eol   <= 1'b0;
            out_last     <= 1'b0;
            out_bank     <= 1'b0;
        end else if (out_load) begin
            io.out_valid <= 1'b1;
            io.out_p     <= mem[{rb, rd_q == RD_ROW1}][rcnt];
            io.out_npx   <= rd_last ? last_npx : 4'd8;
            io.out_sol   <= (rcnt == '0);
            io.out_eol   <= rd_last;
            out_last     <= rd_last && (rd_q == RD_ROW1);
            out_bank     <= rb;
        end else if (out_hs) begin
            io.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decoder_blk2raster.sv
// Bench for the block-to-raster buffer: random blocks in, raster segments out,
// checked against a band-level reference model.
`timescale 1ns/1ps
module tb_decoder_blk2raster;
    localparam int MSW = 2560;
    localparam int SWW = $clog2(MSW);
    localparam int PW  = 14;

    typedef struct {
        logic [335:0] d;
        logic [3:0]   npx;
        logic         sol;
        logic         eol;
    } seg_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           flush;
    logic [SWW-1:0] slice_width;
    logic           overflow_err;

    int checks = 0;
    int errors = 0;

    seg_t         exp_q[$];
    logic [671:0] band_q[$];

    decoder_blk2raster_if io();

    decoder_blk2raster #(.MAX_SLICE_WIDTH(MSW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .slice_width  (slice_width),
        .io           (io),
        .overflow_err (overflow_err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic logic [671:0] rand_blk();
        logic [671:0] b;
        for (int i = 0; i < 48; i++) b[i*PW +: PW] = PW'($urandom);
        return b;
    endfunction

    function automatic logic [335:0] seg_mask(input logic [3:0] npx);
        logic [335:0] m = '0;
        for (int cp = 0; cp < 3; cp++)
            for (int x = 0; x < 8; x++)
                if (x < int'(npx)) m[(cp*8+x)*PW +: PW] = '1;
        return m;
    endfunction

    // Reference: once NB blocks of a band are in, the band yields row 0 then row 1,
    // one segment per block column.
    function automatic void model_accept(input logic [671:0] blk, input int sw);
        int nb = (sw + 7) / 8;
        band_q.push_back(blk);
        if (band_q.size() == nb) begin
            for (int r = 0; r < 2; r++) begin
                for (int k = 0; k < nb; k++) begin
                    seg_t s;
                    s.d = '0;
                    for (int cp = 0; cp < 3; cp++)
                        for (int x = 0; x < 8; x++)
                            s.d[(cp*8+x)*PW +: PW] = band_q[k][(cp*16+r*8+x)*PW +: PW];
                    s.npx = (k == nb - 1) ? 4'(sw - 8*(nb-1)) : 4'd8;
                    s.sol = (k == 0);
                    s.eol = (k == nb - 1);
                    exp_q.push_back(s);
                end
            end
            band_q.delete();
        end
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({io.in_ready, io.out_valid, io.out_npx, io.out_sol, io.out_eol, overflow_err} !== 9'b1_0_0000_0_0_0
            || io.out_p !== '0) begin
            errors++;
            $display("[TB] FAIL reset_hold: got rdy=%b vld=%b npx=%0d sol=%b eol=%b err=%b, expected 1 0 0 0 0 0",
                     io.in_ready, io.out_valid, io.out_npx, io.out_sol, io.out_eol, overflow_err);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0 || overflow_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle: got rdy=%b vld=%b err=%b, expected 1 0 0",
                     io.in_ready, io.out_valid, overflow_err);
        end
    endtask

    // Streams nbands random bands; rmode 0 = out_ready high, 1 = toggling, 2 = random.
    task automatic test_stream(input int sw, input int nbands, input int rmode, input string name);
        int nb = (sw + 7) / 8;
        int total = nbands * nb;
        int sent = 0, got = 0, cyc = 0, acc_nb = -1, first_v = -1, gap = 0, extra = 0;
        bit have = 0;
        logic [671:0] cur = '0;
        logic [335:0] m;
        seg_t e;
        slice_width = SWW'(sw);
        flush = 1'b0;
        exp_q.delete();
        band_q.delete();
        while (got < 2*total && cyc < 4000) begin
            @(negedge clk);
            if (!have && sent < total) begin
                cur  = rand_blk();
                have = 1;
            end
            io.in_p     = cur;
            io.in_valid = have && io.in_ready && (rmode == 0 || $urandom_range(0, 3) != 0);
            case (rmode)
                0:       io.out_ready = 1'b1;
                1:       io.out_ready = (cyc % 2 == 0);
                default: io.out_ready = ($urandom_range(0, 2) != 0);
            endcase
            if (io.in_valid && io.in_ready) begin
                model_accept(cur, sw);
                have = 0;
                sent++;
                if (sent == nb) acc_nb = cyc;
            end
            if (io.out_valid && first_v < 0) first_v = cyc;
            if (first_v >= 0 && !io.out_valid) gap++;
            if (io.out_valid && io.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL %s extra_seg %0d: got unexpected segment, expected none", name, got);
                end else begin
                    e = exp_q.pop_front();
                    m = seg_mask(e.npx);
                    if ((io.out_p & m) !== (e.d & m) || io.out_npx !== e.npx
                        || io.out_sol !== e.sol || io.out_eol !== e.eol) begin
                        errors++;
                        $display("[TB] FAIL %s seg %0d: got p=%h npx=%0d sol=%b eol=%b, expected p=%h npx=%0d sol=%b eol=%b",
                                 name, got, io.out_p & m, io.out_npx, io.out_sol, io.out_eol,
                                 e.d & m, e.npx, e.sol, e.eol);
                    end
                end
                got++;
            end
            cyc++;
        end
        io.in_valid = 1'b0;
        checks++;
        if (got != 2*total) begin
            errors++;
            $display("[TB] FAIL %s count: got %0d segments, expected %0d", name, got, 2*total);
        end
        checks++;
        if (first_v != acc_nb + 3) begin
            errors++;
            $display("[TB] FAIL %s latency: got first valid at cycle %0d, expected %0d", name, first_v, acc_nb + 3);
        end
        if (rmode == 0) begin
            checks++;
            if (gap != 0) begin
                errors++;
                $display("[TB] FAIL %s gap: got %0d idle cycles, expected 0", name, gap);
            end
        end
        io.out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (io.out_valid) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("[TB] FAIL %s idle_after: got %0d valid cycles, expected 0", name, extra);
        end
    endtask

    task automatic test_basic();
        test_stream(32, 1, 0, "basic_nb4");
    endtask

    task automatic test_partial_width();
        test_stream(20, 1, 0, "partial_nb3");
        test_stream(20, 2, 2, "partial_rand");
        test_stream(8, 3, 2, "single_block");
    endtask

    task automatic test_back_to_back();
        test_stream(32, 3, 0, "b2b_full_rate");
        test_stream(32, 3, 1, "b2b_toggle");
    endtask

    task automatic test_overflow();
        int acc = 0, hold_bad = 0;
        bit held_set = 0;
        logic [335:0] held = '0;
        logic [671:0] blk;
        slice_width = SWW'(32);
        exp_q.delete();
        band_q.delete();
        io.out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            blk = rand_blk();
            io.in_p     = blk;
            io.in_valid = 1'b1;
            if (io.in_ready) begin
                model_accept(blk, 32);
                acc++;
            end
            if (io.out_valid) begin
                if (!held_set) begin
                    held     = io.out_p;
                    held_set = 1;
                end else if (io.out_p !== held) begin
                    hold_bad++;
                end
            end
        end
        @(negedge clk);
        io.in_valid = 1'b0;
        checks++;
        if (acc != 8) begin
            errors++;
            $display("[TB] FAIL ovf_accepts: got %0d, expected 8", acc);
        end
        checks++;
        if (overflow_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_err: got %b, expected 1", overflow_err);
        end
        checks++;
        if (io.out_valid !== 1'b1 || hold_bad != 0 || exp_q.size() == 0 || io.out_p !== exp_q[0].d
            || io.out_sol !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_hold: got vld=%b changes=%0d sol=%b p=%h, expected 1 0 1 first segment",
                     io.out_valid, hold_bad, io.out_sol, io.out_p);
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0 || overflow_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_clear: got rdy=%b vld=%b err=%b, expected 1 0 0",
                     io.in_ready, io.out_valid, overflow_err);
        end
        io.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            io.in_p     = rand_blk();
            io.in_valid = 1'b1;
        end
        @(negedge clk);
        flush       = 1'b1;
        io.in_p     = rand_blk();
        io.in_valid = 1'b1;
        @(negedge clk);
        flush       = 1'b0;
        io.in_valid = 1'b0;
        checks++;
        if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0 || overflow_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_partial: got rdy=%b vld=%b err=%b, expected 1 0 0",
                     io.in_ready, io.out_valid, overflow_err);
        end
        test_stream(32, 1, 0, "post_flush");
    endtask

    task automatic test_reset_mid_drain();
        int hs = 0, sent = 0, cyc = 0;
        slice_width  = SWW'(32);
        io.out_ready = 1'b1;
        while (hs < 5 && cyc < 200) begin
            @(negedge clk);
            io.in_p     = rand_blk();
            io.in_valid = (sent < 4);
            if (io.in_valid && io.in_ready) sent++;
            if (io.out_valid && io.out_ready) hs++;
            cyc++;
        end
        @(negedge clk);
        io.in_valid = 1'b0;
        checks++;
        if (hs != 5 || io.out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_drain_setup: got %0d handshakes vld=%b, expected 5 1", hs, io.out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({io.in_ready, io.out_valid, io.out_npx, io.out_sol, io.out_eol, overflow_err} !== 9'b1_0_0000_0_0_0
            || io.out_p !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset: got rdy=%b vld=%b npx=%0d sol=%b eol=%b err=%b, expected 1 0 0 0 0 0",
                     io.in_ready, io.out_valid, io.out_npx, io.out_sol, io.out_eol, overflow_err);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_stream(32, 1, 2, "post_reset");
    endtask

    // Test sequence.
    initial begin
        io.in_valid  = 1'b0;
        io.in_p      = '0;
        io.out_ready = 1'b0;
        flush        = 1'b0;
        slice_width  = SWW'(32);
        rst_n        = 1'b0;
        test_reset();
        test_basic();
        test_partial_width();
        test_back_to_back();
        test_overflow();
        test_flush();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
